// File: rtl/lift_pkg.sv
// Shared types and constants for the single-car SCAN lift scheduler.
// Call-position helpers are used by the scheduler's direction decisions.
package lift_pkg;

    localparam int MAX_FLOORS = 16;
    localparam int FLOOR_W    = 4;
    localparam int CNT_W      = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } lift_state_e;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DOWN = 2'b10;

    function automatic logic calls_above(input logic [MAX_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i > int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

    function automatic logic calls_below(input logic [MAX_FLOORS-1:0] p,
                                         input logic [FLOOR_W-1:0]    f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < MAX_FLOORS; i++) begin
            if (i < int'(f) && p[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lift_scheduler_if.sv
// Call/pacing inputs and car status outputs of the lift scheduler.
interface lift_scheduler_if;
    import lift_pkg::*;

    logic                  tick;
    logic [MAX_FLOORS-1:0] call_req;
    logic                  door_hold;
    logic [FLOOR_W-1:0]    floor;
    logic                  door_open;
    logic [1:0]            dir;
    logic [MAX_FLOORS-1:0] pending;

    modport master (output tick, call_req, door_hold,
                    input  floor, door_open, dir, pending);
    modport slave  (input  tick, call_req, door_hold,
                    output floor, door_open, dir, pending);
endinterface

// File: rtl/lift_tick_timer.sv
// Tick-gated down counter shared by the travel and door intervals.
// done is high while the remaining count is zero.
module lift_tick_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic             hold,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A tick coinciding with a load already counts against the new interval.
    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = load_val;
        end else if (load) begin
            cnt_d = (tick && load_val != '0) ? load_val - CNT_W'(1) : load_val;
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done = (cnt_q == '0);
endmodule

// File: rtl/lift_scheduler.sv
// Single-car SCAN lift scheduler. Define LIFT_DOOR_HOLD_EN to let door_hold
// keep the door open; otherwise door_hold is ignored.
//  state     | meaning
//  IDLE      | no motion, door closed, waiting for a call
//  MOVE_UP   | travelling one floor up per travel interval
//  MOVE_DOWN | travelling one floor down per travel interval
//  DOOR_OPEN | stopped at a called floor with the door open
module lift_scheduler
    import lift_pkg::*;
#(
    parameter int N_FLOORS     = 16,
    parameter int HOME_FLOOR   = 3,
    parameter int TRAVEL_TICKS = 2,
    parameter int DOOR_TICKS   = 5
) (
    input logic             clk,
    input logic             rst_n,
    lift_scheduler_if.slave bus
);
    localparam logic [FLOOR_W-1:0]    HOME       = FLOOR_W'(HOME_FLOOR);
    localparam logic [FLOOR_W-1:0]    TOP        = FLOOR_W'(N_FLOORS - 1);
    localparam logic [MAX_FLOORS-1:0] FLOOR_MASK = MAX_FLOORS'((32'd1 << N_FLOORS) - 32'd1);
    localparam logic [CNT_W-1:0]      TRAVEL_VAL = CNT_W'(TRAVEL_TICKS);
    localparam logic [CNT_W-1:0]      DOOR_VAL   = CNT_W'(DOOR_TICKS);

    lift_state_e           state_q, state_d;
    logic [FLOOR_W-1:0]    floor_q, floor_d;
    logic [1:0]            dir_q, dir_d;
    logic [1:0]            last_dir_q, last_dir_d;
    logic [MAX_FLOORS-1:0] pending_q, pending_d;

    logic [MAX_FLOORS-1:0] call_mask, clr;
    logic [CNT_W-1:0]      tmr_val;
    logic                  tmr_load, tmr_hold, tmr_done, hold_active;
    logic                  up_calls, dn_calls, here, ahead, behind, go_door, go_idle;
    logic [1:0]            go_dir, rev_dir;

`ifdef LIFT_DOOR_HOLD_EN
    assign hold_active = (state_q == DOOR_OPEN) && bus.door_hold;
`else
    assign hold_active = 1'b0;
`endif

    lift_tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (bus.tick),
        .load     (tmr_load),
        .hold     (tmr_hold),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_d    = state_q;
        floor_d    = floor_q;
        dir_d      = dir_q;
        last_dir_d = last_dir_q;
        tmr_load   = 1'b0;
        tmr_hold   = 1'b0;
        tmr_val    = TRAVEL_VAL;
        go_dir     = DIR_IDLE;
        go_door    = 1'b0;
        go_idle    = 1'b0;
        call_mask  = bus.call_req & FLOOR_MASK;

        // Decisions at the end of a travel interval look at the floor just reached.
        if (state_q == MOVE_UP && tmr_done && floor_q != TOP)
            floor_d = floor_q + FLOOR_W'(1);
        else if (state_q == MOVE_DOWN && tmr_done && floor_q != '0)
            floor_d = floor_q - FLOOR_W'(1);

        up_calls = calls_above(pending_q, floor_d);
        dn_calls = calls_below(pending_q, floor_d);
        here     = pending_q[floor_d];
        ahead    = (last_dir_q == DIR_UP) ? up_calls : dn_calls;
        behind   = (last_dir_q == DIR_UP) ? dn_calls : up_calls;
        rev_dir  = (last_dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;

        case (state_q)
            IDLE: begin
                if (here)                      go_door = 1'b1;
                else if (up_calls && dn_calls) go_dir  = last_dir_q;
                else if (up_calls)             go_dir  = DIR_UP;
                else if (dn_calls)             go_dir  = DIR_DOWN;
            end
            MOVE_UP, MOVE_DOWN: begin
                if (tmr_done) begin
                    if (here)        go_door = 1'b1;
                    else if (ahead)  go_dir  = last_dir_q;
                    else if (behind) go_dir  = rev_dir;
                    else             go_idle = 1'b1;
                end
            end
            DOOR_OPEN: begin
                if (hold_active) begin
                    tmr_hold = 1'b1;
                    tmr_val  = DOOR_VAL;
                end else if (call_mask[floor_q]) begin
                    tmr_load = 1'b1;
                    tmr_val  = DOOR_VAL;
                end else if (tmr_done) begin
                    if (ahead)       go_dir  = last_dir_q;
                    else if (behind) go_dir  = rev_dir;
                    else             go_idle = 1'b1;
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_door) begin
            state_d  = DOOR_OPEN;
            tmr_load = 1'b1;
            tmr_val  = DOOR_VAL;
            if (state_q == IDLE) dir_d = DIR_IDLE;
        end else if (go_dir == DIR_UP) begin
            state_d    = MOVE_UP;
            dir_d      = DIR_UP;
            last_dir_d = DIR_UP;
            tmr_load   = 1'b1;
        end else if (go_dir == DIR_DOWN) begin
            state_d    = MOVE_DOWN;
            dir_d      = DIR_DOWN;
            last_dir_d = DIR_DOWN;
            tmr_load   = 1'b1;
        end else if (go_idle) begin
            state_d = IDLE;
            dir_d   = DIR_IDLE;
        end

        clr       = (state_q == DOOR_OPEN || state_d == DOOR_OPEN) ?
                    (MAX_FLOORS'(1) << floor_d) : '0;
        pending_d = (pending_q | call_mask) & ~clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            floor_q    <= HOME;
            dir_q      <= DIR_IDLE;
            last_dir_q <= DIR_UP;
            pending_q  <= '0;
        end else begin
            state_q    <= state_d;
            floor_q    <= floor_d;
            dir_q      <= dir_d;
            last_dir_q <= last_dir_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.floor     = floor_q;
    assign bus.door_open = (state_q == DOOR_OPEN);
    assign bus.dir       = dir_q;
    assign bus.pending   = pending_q;
endmodule
